// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: phase enum, lamp codes, lamp helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        WALK   = 2'd3
    } state_e;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // Lamp code shown by the approach that owns the current phase
    function automatic logic [1:0] active_lamp(input state_e st);
        case (st)
            GREEN:   return LIGHT_GREEN;
            YELLOW:  return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter used to time each traffic phase; flags when it reaches zero.
module phase_timer #(
    parameter int unsigned       CNT_W     = 8,
    parameter logic [CNT_W-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_hold,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over hold; otherwise count down by one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (!i_hold) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/traffic_controller.sv
// Multi-approach round-robin traffic-light controller with emergency preempt.
// Optional pedestrian walk phase is built when PED_REQ_EN is defined.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR    = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_CYC  = 20,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned WALK_CYC   = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       preempt,
`ifdef PED_REQ_EN
    input  logic                       ped_req,
`endif
    output logic [2*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       walk,
    output logic                       phase_done
);

    localparam int unsigned DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYC - 1);

    state_e              r_state;
    logic [DIR_W-1:0]    r_dir;
    logic [2*NUM_DIR-1:0] r_lights;

    state_e              w_state_nxt;
    logic [DIR_W-1:0]    w_dir_nxt;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_hold;
    logic                w_zero;
    logic                w_ped_go;

    // Only the active approach may show a non-red lamp
    function automatic logic [2*NUM_DIR-1:0] decode_lights(input state_e st,
                                                           input logic [DIR_W-1:0] dir);
        logic [2*NUM_DIR-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            if (DIR_W'(i) == dir) begin
                v[2*i +: 2] = active_lamp(st);
            end
        end
        return v;
    endfunction

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (LD_ALLRED)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_hold     (w_hold),
        .o_zero     (w_zero)
    );

    // Next phase, next approach and timer control
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_load      = 1'b0;
        w_load_val  = LD_ALLRED;
        w_hold      = ~enable;
        case (r_state)
            ALLRED: begin
                if (preempt) begin
                    // Keep clearance re-armed so release restarts a full all-red
                    w_load     = 1'b1;
                    w_load_val = LD_ALLRED;
                end else if (enable && w_zero) begin
                    w_load = 1'b1;
                    if (w_ped_go) begin
                        w_state_nxt = WALK;
                        w_load_val  = LD_WALK;
                    end else begin
                        w_state_nxt = GREEN;
                        w_load_val  = LD_GREEN;
                    end
                end
            end
            GREEN: begin
                if (preempt || (enable && w_zero)) begin
                    w_state_nxt = YELLOW;
                    w_load      = 1'b1;
                    w_load_val  = LD_YELLOW;
                end
            end
            YELLOW: begin
                if (enable && w_zero) begin
                    w_state_nxt = ALLRED;
                    w_load      = 1'b1;
                    w_load_val  = LD_ALLRED;
                    w_dir_nxt   = (r_dir == DIR_W'(NUM_DIR - 1)) ? '0 : r_dir + DIR_W'(1);
                end
            end
            WALK: begin
                if (preempt) begin
                    w_state_nxt = ALLRED;
                    w_load      = 1'b1;
                    w_load_val  = LD_ALLRED;
                end else if (enable && w_zero) begin
                    w_state_nxt = GREEN;
                    w_load      = 1'b1;
                    w_load_val  = LD_GREEN;
                end
            end
            default: begin
                w_state_nxt = ALLRED;
                w_load      = 1'b1;
                w_load_val  = LD_ALLRED;
            end
        endcase
    end

    // Phase register with lamp outputs decoded from the next phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ALLRED;
            r_dir    <= '0;
            r_lights <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_lights <= decode_lights(w_state_nxt, w_dir_nxt);
        end
    end

`ifdef PED_REQ_EN
    logic r_pend;
    logic r_walk;

    // Pedestrian request latch, consumed on entry to the walk phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 1'b0;
            r_walk <= 1'b0;
        end else begin
            r_walk <= (w_state_nxt == WALK);
            if ((w_state_nxt == WALK) && (r_state != WALK)) begin
                r_pend <= 1'b0;
            end else if (ped_req) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign w_ped_go = r_pend;
    assign walk     = r_walk;
`else
    assign w_ped_go = 1'b0;
    assign walk     = 1'b0;
`endif

    assign lights     = r_lights;
    assign active_dir = r_dir;
    assign phase_done = enable & w_zero & ~(preempt & (r_state == ALLRED));

endmodule

// File: tb/tb_traffic_controller.sv
// Randomized self-checking bench for traffic_controller against a phase/elapsed-time model.
module tb_traffic_controller;

    localparam int unsigned NUM_DIR    = 3;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned GREEN_CYC  = 20;
    localparam int unsigned YELLOW_CYC = 4;
    localparam int unsigned ALLRED_CYC = 2;
    localparam int unsigned WALK_CYC   = 10;
    localparam int unsigned DIR_W      = $clog2(NUM_DIR);

`ifdef PED_REQ_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    localparam int P_ALLRED = 0;
    localparam int P_GREEN  = 1;
    localparam int P_YELLOW = 2;
    localparam int P_WALK   = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic                 preempt;
`ifdef PED_REQ_EN
    logic                 ped_req;
`endif
    logic [2*NUM_DIR-1:0] lights;
    logic [DIR_W-1:0]     active_dir;
    logic                 walk;
    logic                 phase_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which phase, how many enabled cycles spent in it, which approach
    int m_phase;
    int m_elapsed;
    int m_dir;
    bit m_pend;

    traffic_controller #(
        .NUM_DIR    (NUM_DIR),
        .CNT_W      (CNT_W),
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .ALLRED_CYC (ALLRED_CYC),
        .WALK_CYC   (WALK_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .preempt    (preempt),
`ifdef PED_REQ_EN
        .ped_req    (ped_req),
`endif
        .lights     (lights),
        .active_dir (active_dir),
        .walk       (walk),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            P_GREEN:  return int'(GREEN_CYC);
            P_YELLOW: return int'(YELLOW_CYC);
            P_WALK:   return int'(WALK_CYC);
            default:  return int'(ALLRED_CYC);
        endcase
    endfunction

    function automatic logic [2*NUM_DIR-1:0] model_lights();
        logic [2*NUM_DIR-1:0] v;
        v = '0;
        if (m_phase == P_GREEN)  v[2*m_dir +: 2] = 2'b10;
        if (m_phase == P_YELLOW) v[2*m_dir +: 2] = 2'b01;
        return v;
    endfunction

    function automatic bit model_done(input bit en, input bit pre);
        return en && (m_elapsed == dur(m_phase) - 1) && !(pre && m_phase == P_ALLRED);
    endfunction

    task automatic model_reset();
        m_phase   = P_ALLRED;
        m_elapsed = 0;
        m_dir     = 0;
        m_pend    = 1'b0;
    endtask

    // One clock of the intersection rules
    task automatic model_step(input bit en, input bit pre, input bit ped);
        bit last;
        bit walk_entry;
        last       = (m_elapsed == dur(m_phase) - 1);
        walk_entry = 1'b0;
        case (m_phase)
            P_ALLRED: begin
                if (pre) m_elapsed = 0;
                else if (en) begin
                    if (last) begin
                        m_elapsed = 0;
                        if (m_pend) begin m_phase = P_WALK; walk_entry = 1'b1; end
                        else m_phase = P_GREEN;
                    end else m_elapsed++;
                end
            end
            P_GREEN: begin
                if (pre || (en && last)) begin m_phase = P_YELLOW; m_elapsed = 0; end
                else if (en) m_elapsed++;
            end
            P_YELLOW: begin
                if (en && last) begin
                    m_phase = P_ALLRED; m_elapsed = 0;
                    m_dir = (m_dir + 1) % int'(NUM_DIR);
                end else if (en) m_elapsed++;
            end
            default: begin
                if (pre) begin m_phase = P_ALLRED; m_elapsed = 0; end
                else if (en && last) begin m_phase = P_GREEN; m_elapsed = 0; end
                else if (en) m_elapsed++;
            end
        endcase
        m_pend = walk_entry ? 1'b0 : (m_pend | (ped & PED_ON));
    endtask

    task automatic check_outputs();
        int nonred;
        nonred = 0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            if (lights[2*i +: 2] != 2'b00) nonred++;
        end
        check("lights", 32'(lights), 32'(model_lights()));
        check("active_dir", 32'(active_dir), 32'(m_dir));
        check("walk", 32'(walk), 32'(m_phase == P_WALK));
        check("single_active", 32'(nonred <= 1), 32'd1);
    endtask

    task automatic do_cycle(input bit en, input bit pre, input bit ped);
        @(negedge clk);
        enable  = en;
        preempt = pre;
`ifdef PED_REQ_EN
        ped_req = ped;
`endif
        #1;
        check("phase_done", 32'(phase_done), 32'(model_done(en, pre)));
        @(posedge clk);
        model_step(en, pre, ped);
        #1;
        check_outputs();
    endtask

    // Run normally until the model reaches the given phase and elapsed count
    task automatic run_to(input string tag, input int ph, input int el);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (m_phase == ph && m_elapsed == el) begin found = 1'b1; break; end
            do_cycle(1'b1, 1'b0, 1'b0);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int walk_cnt;
        bit pre_state;
        reset_n = 1'b0;
        enable  = 1'b0;
        preempt = 1'b0;
`ifdef PED_REQ_EN
        ped_req = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_lights", 32'(lights), 32'd0);
        check("rst_dir", 32'(active_dir), 32'd0);
        check("rst_walk", 32'(walk), 32'd0);
        check("rst_phase_done", 32'(phase_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free-running sequence from reset
        repeat (60) do_cycle(1'b1, 1'b0, 1'b0);

        // Preempt mid-green, held then released
        run_to("reach_green5", P_GREEN, 5);
        repeat (30) do_cycle(1'b1, 1'b1, 1'b0);
        repeat (40) do_cycle(1'b1, 1'b0, 1'b0);

        // Freeze mid-green
        run_to("reach_green8", P_GREEN, 8);
        repeat (10) do_cycle(1'b0, 1'b0, 1'b0);
        repeat (40) do_cycle(1'b1, 1'b0, 1'b0);

        // Pedestrian request during green
        run_to("reach_green3", P_GREEN, 3);
        do_cycle(1'b1, 1'b0, 1'b1);
        walk_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0);
            if (walk) walk_cnt++;
        end
        check("walk_cycles", 32'(walk_cnt), PED_ON ? 32'(WALK_CYC) : 32'd0);

        // Randomized enable / preempt bursts / pedestrian pulses
        pre_state = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) pre_state = ~pre_state;
            do_cycle($urandom_range(0, 7) != 0, pre_state, $urandom_range(0, 29) == 0);
        end
        repeat (40) do_cycle(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of yellow
        run_to("reach_yellow1", P_YELLOW, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_lights", 32'(lights), 32'd0);
        check("arst_dir", 32'(active_dir), 32'd0);
        check("arst_walk", 32'(walk), 32'd0);
        enable  = 1'b0;
        preempt = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) do_cycle(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_controller.md
# traffic_controller

Parametrised multi-approach traffic-light controller: the next generation of the team's free-running light sequencer. Serves NUM_DIR approaches round-robin with programmable green/yellow/all-red dwell times, an emergency preempt that forces all-red, and an optional pedestrian walk phase. Sits at the intersection-control level of the airport perimeter design and drives the per-approach lamp drivers directly.

## Interface
- NUM_DIR, 2: number of vehicle approaches, 2..8
- CNT_W, 8: phase timer width
- GREEN_CYC, 20: green dwell in cycles, 1..2^CNT_W
- YELLOW_CYC, 4: yellow dwell in cycles, 1..2^CNT_W
- ALLRED_CYC, 2: all-red clearance in cycles, 1..2^CNT_W
- WALK_CYC, 10: pedestrian walk dwell in cycles, 1..2^CNT_W (used only with PED_REQ_EN)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high = sequence advances; low = state and timer frozen
- preempt  in  1  emergency request, level; forces all-red while high
- ped_req  in  1  pedestrian request pulse (present only with PED_REQ_EN)
- lights  out  2*NUM_DIR  per-approach code, bits [2i+1:2i] = approach i: 00 red, 01 yellow, 10 green; 11 never driven
- active_dir  out  $clog2(NUM_DIR)  approach currently owning green/yellow (or next to be served)
- walk  out  1  pedestrian walk lamp (constant 0 without PED_REQ_EN)
- phase_done  out  1  high in the last cycle of every phase

## Operation
- States: ALLRED, GREEN, YELLOW, WALK (WALK only with PED_REQ_EN).
- Phase timer loads duration-1 on phase entry, decrements each enabled cycle; phase ends on the enabled cycle where timer == 0.
- Normal sequence: ALLRED -> GREEN(active_dir) -> YELLOW(active_dir) -> ALLRED, active_dir increments on YELLOW->ALLRED, wrapping NUM_DIR-1 -> 0.
- lights: only active_dir shows non-red, and only in GREEN (10) or YELLOW (01); all approaches 00 in ALLRED and WALK.
- Preempt (acts regardless of enable):
  - in GREEN: next cycle enters YELLOW, full YELLOW_CYC dwell.
  - in YELLOW: yellow completes normally.
  - in ALLRED: timer held at ALLRED_CYC-1 while preempt high; after release, full ALLRED_CYC then GREEN.
  - in WALK: next cycle enters ALLRED; walk drops.
  - Preempt rising during final YELLOW cycle: normal YELLOW->ALLRED, then held.
- enable low with preempt low: all registers hold; lights unchanged; phase_done 0.
- Reset: state ALLRED, timer ALLRED_CYC-1, active_dir 0, lights all 00, walk 0, phase_done 0, ped pending cleared. Reset mid-phase aborts immediately to this state.

## Timing
- lights, active_dir, walk are decoded from registered state: change on the same edge as the state, no extra latency.
- With enable high and no preempt: each phase lasts exactly its *_CYC cycles; one full approach cycle = GREEN_CYC+YELLOW_CYC+ALLRED_CYC.
- phase_done is combinational from timer == 0 and advancing condition; never high while frozen or during preempt hold.
- First GREEN after reset release begins ALLRED_CYC cycles after reset_n deasserts (enable high).

## Configuration
- PED_REQ_EN defined: ped_req port present; a high ped_req sample sets a pending flag (further requests merge). At the end of ALLRED, if pending and preempt low, enter WALK (walk = 1, all lights 00) for WALK_CYC cycles, clear pending on entry, then GREEN(active_dir). A request arriving during WALK is kept pending for the next ALLRED.
- PED_REQ_EN undefined: no ped_req port, no WALK state, walk tied 0.

## Structure
- Package traffic_pkg: state enum (ALLRED, GREEN, YELLOW, WALK), light code constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN.
- Sub-module phase_timer: CNT_W loadable down counter with load, hold and zero flag; controller FSM owns sequencing and output decode.

## Test plan
- Defaults, enable high 60 cycles after reset -> ALLRED 2, approach 0 green 20, yellow 4, ALLRED 2, approach 1 green; phase_done pulses at cycles 1, 21, 25, 27.
- NUM_DIR=3 run 3 full cycles -> active_dir 0,1,2,0 wrap; never two approaches non-red.
- preempt high at green cycle 5 for 30 cycles -> yellow next cycle for 4, all-red held, release -> 2 all-red then next approach green.
- enable low 10 cycles mid-green -> lights and timer frozen; green totals 20 enabled cycles.
- reset_n low mid-yellow -> lights 00, active_dir 0, state ALLRED asynchronously.
- PED_REQ_EN, ped_req pulse during green -> after yellow and ALLRED, walk=1 for 10 cycles with all red, then next green; without macro walk stays 0.
